// File: rtl/vc_dest_demux.sv
// Purpose: picks the VC0/VC1 FIFO read word one cycle after the arbiter's pop strobe and routes it to D0 or D1 by a destination bit.
// Latency: strobe at edge N, data/full sampled at edge N+1, registered push visible from N+1 to N+2; one word per cycle.
// Backpressure: none toward the arbiter; a word aimed at a full destination is dropped and flagged sticky overflow_err.
module vc_dest_demux #(
    parameter int DATA_WIDTH  = 6,
    parameter int DEST_BIT    = 4,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   VC0_rd,
    input  logic                   VC1_rd,
    input  logic [DATA_WIDTH-1:0]  VC0_data,
    input  logic [DATA_WIDTH-1:0]  VC1_data,
    input  logic                   D0_full,
    input  logic                   D1_full,
    output logic                   D0_push,
    output logic [DATA_WIDTH-1:0]  D0_data,
    output logic                   D1_push,
    output logic [DATA_WIDTH-1:0]  D1_data,
    output logic [COUNT_WIDTH-1:0] count_D0,
    output logic [COUNT_WIDTH-1:0] count_D1,
    output logic                   overflow_err,
    output logic                   protocol_err
);

    // Stage 1 state: a read is in flight and which VC it came from (0 = VC0, 1 = VC1)
    logic rd_valid_q, rd_valid_d;
    logic sel_q, sel_d;

    // Stage 2 state: registered destination strobes/data, counters and sticky flags
    logic                   d0_push_q, d0_push_d;
    logic                   d1_push_q, d1_push_d;
    logic [DATA_WIDTH-1:0]  d0_data_q, d0_data_d;
    logic [DATA_WIDTH-1:0]  d1_data_q, d1_data_d;
    logic [COUNT_WIDTH-1:0] count_d0_q, count_d0_d;
    logic [COUNT_WIDTH-1:0] count_d1_q, count_d1_d;
    logic                   overflow_err_q, overflow_err_d;
    logic                   protocol_err_q, protocol_err_d;

    // Combinational view of the word arriving this cycle
    logic [DATA_WIDTH-1:0] word;
    logic                  dest;
    logic                  tgt_full;

    // Capture which VC was popped; a double strobe is resolved to VC0 and flagged
    always_comb begin
        rd_valid_d     = VC0_rd | VC1_rd;
        sel_d          = VC1_rd & ~VC0_rd;
        protocol_err_d = protocol_err_q | (VC0_rd & VC1_rd);
    end

    // Pick the FIFO data for the read captured last cycle and look up its target's full flag
    always_comb begin
        word     = sel_q ? VC1_data : VC0_data;
        dest     = word[DEST_BIT];
        tgt_full = dest ? D1_full : D0_full;
    end

    // Route the word: push and count on a free destination, drop and flag on a full one
    always_comb begin
        d0_push_d      = 1'b0;
        d1_push_d      = 1'b0;
        d0_data_d      = d0_data_q;
        d1_data_d      = d1_data_q;
        count_d0_d     = count_d0_q;
        count_d1_d     = count_d1_q;
        overflow_err_d = overflow_err_q;
        if (rd_valid_q) begin
            if (tgt_full) begin
                // Dropped words are not held; the flag is the only trace left
                overflow_err_d = 1'b1;
            end else if (dest == 1'b0) begin
                d0_push_d  = 1'b1;
                d0_data_d  = word;
                count_d0_d = count_d0_q + COUNT_WIDTH'(1);
            end else begin
                d1_push_d  = 1'b1;
                d1_data_d  = word;
                count_d1_d = count_d1_q + COUNT_WIDTH'(1);
            end
        end
    end

    // State registers with synchronous reset; in-flight reads are discarded on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q     <= 1'b0;
            sel_q          <= 1'b0;
            d0_push_q      <= 1'b0;
            d1_push_q      <= 1'b0;
            d0_data_q      <= '0;
            d1_data_q      <= '0;
            count_d0_q     <= '0;
            count_d1_q     <= '0;
            overflow_err_q <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            rd_valid_q     <= rd_valid_d;
            sel_q          <= sel_d;
            d0_push_q      <= d0_push_d;
            d1_push_q      <= d1_push_d;
            d0_data_q      <= d0_data_d;
            d1_data_q      <= d1_data_d;
            count_d0_q     <= count_d0_d;
            count_d1_q     <= count_d1_d;
            overflow_err_q <= overflow_err_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign D0_push      = d0_push_q;
    assign D1_push      = d1_push_q;
    assign D0_data      = d0_data_q;
    assign D1_data      = d1_data_q;
    assign count_D0     = count_d0_q;
    assign count_D1     = count_d1_q;
    assign overflow_err = overflow_err_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_vc_dest_demux.sv
// Bench for vc_dest_demux: directed scenarios with literal expectations, then randomized traffic.
// A queue-based reference model predicts every output; a negedge process compares each cycle.
module tb_vc_dest_demux;

    localparam int DW = 6;
    localparam int DB = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          VC0_rd, VC1_rd;
    logic [DW-1:0] VC0_data, VC1_data;
    logic          D0_full, D1_full;
    logic          D0_push, D1_push;
    logic [DW-1:0] D0_data, D1_data;
    logic [CW-1:0] count_D0, count_D1;
    logic          overflow_err, protocol_err;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    vc_dest_demux #(.DATA_WIDTH(DW), .DEST_BIT(DB), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .VC0_rd(VC0_rd), .VC1_rd(VC1_rd),
        .VC0_data(VC0_data), .VC1_data(VC1_data),
        .D0_full(D0_full), .D1_full(D1_full),
        .D0_push(D0_push), .D0_data(D0_data),
        .D1_push(D1_push), .D1_data(D1_data),
        .count_D0(count_D0), .count_D1(count_D1),
        .overflow_err(overflow_err), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Pending reads are a queue of source VC ids; each one is served by the data present one edge later.
    int      pend[$];
    bit      m_p0, m_p1, m_ovf, m_prot;
    int      m_d0, m_d1, m_c0, m_c1;

    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            m_p0 = 0; m_p1 = 0; m_d0 = 0; m_d1 = 0;
            m_c0 = 0; m_c1 = 0; m_ovf = 0; m_prot = 0;
        end else begin
            m_p0 = 0; m_p1 = 0;
            if (pend.size() > 0) begin
                int src;
                int w;
                int dst;
                src = pend.pop_front();
                w   = (src == 1) ? int'(VC1_data) : int'(VC0_data);
                dst = (w >> DB) & 1;
                if ((dst == 0 && D0_full) || (dst == 1 && D1_full)) m_ovf = 1;
                else if (dst == 0) begin m_p0 = 1; m_d0 = w; m_c0 = (m_c0 + 1) % (1 << CW); end
                else               begin m_p1 = 1; m_d1 = w; m_c1 = (m_c1 + 1) % (1 << CW); end
            end
            if (VC0_rd && VC1_rd) m_prot = 1;
            if (VC0_rd || VC1_rd) pend.push_back(VC0_rd ? 0 : 1);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("D0_push", 32'(D0_push), 32'(m_p0));
            check("D1_push", 32'(D1_push), 32'(m_p1));
            check("D0_data", 32'(D0_data), 32'(m_d0));
            check("D1_data", 32'(D1_data), 32'(m_d1));
            check("count_D0", 32'(count_D0), 32'(m_c0));
            check("count_D1", 32'(count_D1), 32'(m_c1));
            check("overflow_err", 32'(overflow_err), 32'(m_ovf));
            check("protocol_err", 32'(protocol_err), 32'(m_prot));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        VC0_rd = 0; VC1_rd = 0; D0_full = 0; D1_full = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); reset = 0;
    endtask

    initial begin
        reset = 1; VC0_rd = 1; VC1_rd = 0; VC0_data = '0; VC1_data = '0;
        D0_full = 0; D1_full = 0;
        tick();
        cmp_en = 1'b1;

        // Reset held with a strobe active: everything stays zero, no push after release
        tick();
        check("rst_all_zero", 32'({D0_push, D1_push, D0_data, D1_data, count_D0, count_D1, overflow_err, protocol_err}), 32'd0);
        reset = 0; VC0_rd = 0;
        tick();
        check("rst_no_push1", 32'({D0_push, D1_push}), 32'd0);
        tick();
        check("rst_no_push2", 32'({D0_push, D1_push}), 32'd0);

        // Basic route: destination bit set sends the word to D1
        do_reset();
        VC0_rd = 1; tick();
        VC0_rd = 0; VC0_data = 6'b010011; tick();
        check("basic_D1_push", 32'(D1_push), 32'd1);
        check("basic_D1_data", 32'(D1_data), 32'h13);
        check("basic_D0_push", 32'(D0_push), 32'd0);
        check("basic_count_D1", 32'(count_D1), 32'd1);

        // Back-to-back alternating sources and destinations
        do_reset();
        VC0_rd = 1; tick();
        VC0_rd = 0; VC1_rd = 1; VC0_data = 6'h05; tick();
        check("b2b_1_D0", 32'({D0_push, D1_push, D0_data}), 32'({1'b1, 1'b0, 6'h05}));
        VC0_rd = 1; VC1_rd = 0; VC1_data = 6'h1A; tick();
        check("b2b_2_D1", 32'({D0_push, D1_push, D1_data}), 32'({1'b0, 1'b1, 6'h1A}));
        VC0_rd = 0; VC0_data = 6'h0F; tick();
        check("b2b_3_D0", 32'({D0_push, D1_push, D0_data}), 32'({1'b1, 1'b0, 6'h0F}));
        check("b2b_counts", 32'({count_D0, count_D1}), 32'({5'd2, 5'd1}));

        // Overflow: D0 full at the data edge drops the word; flag stays through clean traffic
        do_reset();
        VC1_rd = 1; tick();
        VC1_rd = 0; VC1_data = 6'h03; D0_full = 1; tick();
        check("ovf_no_push", 32'({D0_push, D1_push}), 32'd0);
        check("ovf_count", 32'(count_D0), 32'd0);
        check("ovf_flag", 32'(overflow_err), 32'd1);
        D0_full = 0; VC0_rd = 1; VC0_data = 6'h02; tick(); tick();
        VC0_rd = 0; tick();
        check("ovf_sticky", 32'({overflow_err, count_D0}), 32'({1'b1, 5'd2}));

        // Protocol violation: both strobes resolve to VC0
        do_reset();
        VC0_rd = 1; VC1_rd = 1; tick();
        VC0_rd = 0; VC1_rd = 0; VC0_data = 6'h01; VC1_data = 6'h11; tick();
        check("prot_push", 32'({D0_push, D1_push, D0_data}), 32'({1'b1, 1'b0, 6'h01}));
        check("prot_flag", 32'(protocol_err), 32'd1);

        // Wrap: 32 D0-bound words bring count_D0 back to zero
        do_reset();
        VC0_rd = 1;
        for (int i = 0; i < 32; i++) begin
            VC0_data = DW'(i & 15);
            tick();
            if (i == 31) VC0_rd = 0;
            if (i == 30) check("wrap_31", 32'(count_D0), 32'd30);
        end
        VC0_data = 6'h0; tick();
        check("wrap_zero", 32'({count_D0, overflow_err, protocol_err, D0_push}), 32'({5'd0, 1'b0, 1'b0, 1'b1}));
        VC0_rd = 0; tick();

        // Randomized traffic with occasional resets, fulls and double strobes
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset    = ($urandom_range(0, 199) == 0);
            VC0_rd   = (r < 40) || (r >= 97);
            VC1_rd   = (r >= 40 && r < 80) || (r >= 97);
            VC0_data = DW'($urandom);
            VC1_data = DW'($urandom);
            D0_full  = ($urandom_range(0, 3) == 0);
            D1_full  = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 0; idle_inputs(); tick(); tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vc_dest_demux.md
# vc_dest_demux

Downstream stage of the VC0/VC1 pop arbiter. Consumes the arbiter's one-hot read strobes and picks the matching FIFO read data one cycle later, when the FIFO presents it. It then routes each word to the D0 or D1 destination FIFO according to a destination bit in the word. Also keeps per-destination delivered-word counters and sticky error flags for overflow and protocol violations.

## Interface
Parameters:
- DATA_WIDTH, 6, width of a VC/D FIFO word
- DEST_BIT, 4, bit index of the destination select (0 → D0, 1 → D1); must be < DATA_WIDTH
- COUNT_WIDTH, 5, width of each delivered-word counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- VC0_rd  in  1  arbiter pop strobe to VC0 FIFO
- VC1_rd  in  1  arbiter pop strobe to VC1 FIFO
- VC0_data  in  DATA_WIDTH  VC0 FIFO read data, valid the cycle after VC0_rd
- VC1_data  in  DATA_WIDTH  VC1 FIFO read data, valid the cycle after VC1_rd
- D0_full  in  1  D0 FIFO full
- D1_full  in  1  D1 FIFO full
- D0_push  out  1  write strobe to D0 FIFO (registered)
- D0_data  out  DATA_WIDTH  write data to D0 FIFO (registered)
- D1_push  out  1  write strobe to D1 FIFO (registered)
- D1_data  out  DATA_WIDTH  write data to D1 FIFO (registered)
- count_D0  out  COUNT_WIDTH  words delivered to D0, wrapping
- count_D1  out  COUNT_WIDTH  words delivered to D1, wrapping
- overflow_err  out  1  sticky: a word targeted a full destination and was dropped
- protocol_err  out  1  sticky: VC0_rd and VC1_rd sampled high together

## Operation
- Stage 1 (select capture), at every posedge:
  - rd_valid_q <= VC0_rd | VC1_rd
  - sel_q <= VC1_rd & ~VC0_rd (0 = VC0, 1 = VC1)
- Both strobes high: treat as VC0 (sel_q = 0) and set protocol_err.
- Stage 2 (mux/demux), at every posedge with rd_valid_q = 1:
  - word = sel_q ? VC1_data : VC0_data; dest = word[DEST_BIT]
  - dest = 0 and D0_full = 0: D0_push <= 1, D0_data <= word, count_D0 <= count_D0 + 1
  - dest = 1 and D1_full = 0: D1_push <= 1, D1_data <= word, count_D1 <= count_D1 + 1
  - target full: no push, no count, overflow_err <= 1; word is dropped, not held
- When rd_valid_q = 0 or the word is dropped: both pushes 0; D0_data/D1_data hold their last value.
- The non-selected destination's push is always 0; at most one push per cycle.
- Counters are modulo 2^COUNT_WIDTH; all-ones + 1 → 0, with no error.
- Sticky flags clear only on reset.
- No back-pressure to the arbiter. The arbiter is responsible for gating on D0_full/D1_full; this block only detects violations.

## Timing
- Reset (reset = 1 at a posedge), all registers cleared: rd_valid_q, sel_q, D0_push, D1_push, D0_data, D1_data, count_D0, count_D1, overflow_err, protocol_err = 0.
- A strobe sampled during reset is discarded; in-flight words are lost and never pushed after reset deasserts.
- Latency: VC*_rd high sampled at edge N → VC*_data sampled at edge N+1 → D*_push high during cycle N+1 to N+2 (one cycle).
- Full check: D*_full is sampled at edge N+1, the same edge as the data, not at the rd edge.
- Throughput: one word per cycle. Back-to-back strobes give back-to-back pushes, including alternating VC0/VC1 and alternating destinations.
- Push is a single-cycle pulse per word; it is never stretched.
- Counters and flags update on the same edge as the corresponding push or drop and are visible the following cycle.

## Test plan
- Reset: hold reset 2 cycles with VC0_rd = 1 → every output 0 throughout; no push in the 2 cycles after release.
- Basic route: VC0_rd pulse, VC0_data = 6'b010011 next cycle → D1_push = 1 with D1_data = 6'b010011 one cycle later; count_D1 = 1, D0_push = 0.
- Back-to-back alternating: VC0_rd, VC1_rd, VC0_rd in consecutive cycles with data 6'h05, 6'h1A, 6'h0F → pushes in consecutive cycles, D0, D1, D0 with matching data; count_D0 = 2, count_D1 = 1.
- Overflow: VC1_rd with data 6'h03 and D0_full = 1 at the data edge → no push, count_D0 unchanged, overflow_err = 1 and stays 1 across later clean traffic.
- Protocol violation: VC0_rd = VC1_rd = 1, VC0_data = 6'h01, VC1_data = 6'h11 → D0_push with 6'h01, protocol_err = 1.
- Wrap: 32 consecutive D0-bound words → count_D0 returns to 0 after the 32nd push; no error flags set.
